// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared constants, issue-pipe record and zero test for the divider arbiter
package fp_div_pkg;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [30:0] FP_INF_MAG = 31'h7F800000;
  typedef struct packed {
    logic        valid;
    logic [1:0]  tag;
    logic        dz;
    logic [31:0] dz_val;
  } div_pipe_t;
  function automatic logic is_zero(input logic [31:0] f);
    return f[30:0] == '0;
  endfunction
endpackage

// File: rtl/fp_div_rsp_fifo.sv
// fp_div_rsp_fifo: per-requester response FIFO, registered head, exposes occupancy
//   clk, rst_n      clock, async active-low reset
//   push, din       write strobe and data
//   pop             consume head (ignored when empty)
//   dout, valid     head entry and non-empty flag
//   count           current occupancy
module fp_div_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rp, wp;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign valid = count != '0;
  assign dout = mem[rp];
  assign do_pop = pop && valid;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wp] <= din;
      if (do_push) wp <= nxt(wp);
      if (do_pop) rp <= nxt(rp);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fp_div_arbiter.sv
// fp_div_arbiter: round-robin sharing of one fixed-latency fp32 divider with credit-protected response FIFOs
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        per-requester request handshake, operands in req_a/req_b slices
//   rsp_valid/rsp_ready        per-requester response handshake, quotient in rsp_data, rsp_dz flag
//   div_a/div_b/div_c          external divider operands and result (result DIV_LAT cycles after issue)
module fp_div_arbiter
  import fp_div_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int DIV_LAT   = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [32*NREQ-1:0]   rsp_data,
  output logic [NREQ-1:0]      rsp_dz,
  output logic [31:0]          div_a,
  output logic [31:0]          div_b,
  input  logic [31:0]          div_c
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int IW = $clog2(NREQ);
  logic [NREQ-1:0] elig, grant;
  logic [IW-1:0] last, gidx, cand;
  logic hs;
  div_pipe_t pipe [DIV_LAT];
  div_pipe_t wb;
  logic [31:0] wb_data;
  // Scan from the farthest candidate down so the nearest one after last wins.
  always_comb begin
    grant = '0;
    gidx = '0;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (elig[cand]) begin
        grant = '0;
        grant[cand] = 1'b1;
        gidx = cand;
      end
    end
    if (!rst_n) grant = '0;
  end
  assign hs = |grant;
  assign req_ready = grant;
  assign div_a = hs ? req_a[32*gidx +: 32] : '0;
  assign div_b = hs ? req_b[32*gidx +: 32] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DIV_LAT; k++) pipe[k] <= '0;
      last <= '0;
    end else begin
      pipe[0] <= '{valid: hs, tag: 2'(gidx), dz: is_zero(div_b),
                   dz_val: is_zero(div_a) ? FP_QNAN : {div_a[31] ^ div_b[31], FP_INF_MAG}};
      for (int k = 1; k < DIV_LAT; k++) pipe[k] <= pipe[k - 1];
      if (hs) last <= gidx;
    end
  end
  // The last stage lines up with the cycle div_c carries that op's quotient.
  assign wb = pipe[DIV_LAT-1];
  assign wb_data = wb.dz ? wb.dz_val : div_c;
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    logic [CW-1:0] inflight, fcnt;
    logic [32:0] dout;
    logic push;
    assign push = wb.valid && wb.tag == 2'(i);
    // Credits count ops in the pipe plus entries waiting in the FIFO; a same-cycle pop is not credited.
    assign elig[i] = req_valid[i] && ({1'b0, inflight} + {1'b0, fcnt}) < (CW+1)'(RSP_DEPTH);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inflight <= '0;
      else inflight <= inflight + CW'(grant[i]) - CW'(push);
    end
    fp_div_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(33)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   ({wb.dz, wb_data}),
      .pop   (rsp_ready[i]),
      .dout  (dout),
      .valid (rsp_valid[i]),
      .count (fcnt)
    );
    assign rsp_data[32*i +: 32] = dout[31:0];
    assign rsp_dz[i] = dout[32];
  end
endmodule
